// File: rtl/uart_byte_tx_if.sv
// Byte handshake between the debug unit's send state machine and the UART transmitter.
interface uart_byte_tx_if;
    logic       tx_start;
    logic [7:0] tx_bus;
    logic       tx_done_tick;
    logic       tx_busy;

    modport master (
        output tx_start,
        output tx_bus,
        input  tx_done_tick,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_bus,
        output tx_done_tick,
        output tx_busy
    );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter with built-in 16x oversampling tick generator.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_byte_tx #(
    parameter int unsigned CLKS_PER_TICK = 163,
    parameter int unsigned DBIT          = 8,
    parameter int unsigned SB_TICK       = 16
) (
    input  logic          top_clk,
    input  logic          top_rst_n,
    uart_byte_tx_if.slave bus,
    output logic          tx
);
    localparam int unsigned TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
`endif

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif
    logic            s_tick;

    assign s_tick           = (tick_q == TW'(CLKS_PER_TICK - 1));
    assign tx               = tx_q;
    assign bus.tx_done_tick = done_q;
    assign bus.tx_busy      = busy_q;

    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        // Tick generator runs only while a frame is in flight.
        if (state_q == ST_IDLE) begin
            tick_d = '0;
        end else begin
            tick_d = s_tick ? '0 : tick_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_start) begin
                    b_d     = DBIT'(bus.tx_bus);
                    s_cnt_d = '0;
                    n_cnt_d = '0;
                    tx_d    = 1'b0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^bus.tx_bus;
`endif
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(15)) begin
                        s_cnt_d = '0;
                        tx_d    = b_q[0];
                        state_d = ST_DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(15)) begin
                        s_cnt_d = '0;
                        b_d     = b_q >> 1;
                        if (n_cnt_q == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx_d    = par_q;
                            state_d = ST_PARITY;
`else
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                            tx_d    = b_d[0];
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(15)) begin
                        s_cnt_d = '0;
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_cnt_q == SW'(SB_TICK - 1)) begin
                        s_cnt_d = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end
endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: table of frames plus random frames checked against a bit-slot line model.
module tb_uart_byte_tx;
    localparam int unsigned C    = 4;
    localparam int unsigned DBIT = 8;
    localparam int unsigned SB   = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int BIT_CYC = 16 * C;
    localparam int FL      = (16 * (1 + DBIT + PAR) + SB) * C;

    logic clk;
    logic rst_n;
    logic tx_line;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   last_e0  = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;

    uart_byte_tx_if bus ();

    uart_byte_tx #(
        .CLKS_PER_TICK(C),
        .DBIT         (DBIT),
        .SB_TICK      (SB)
    ) dut (
        .top_clk  (clk),
        .top_rst_n(rst_n),
        .bus      (bus),
        .tx       (tx_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Expected line level t cycles after the accepting edge: one level per 16*C slot.
    function automatic logic model_tx(input logic [7:0] d, input int t);
        int slot;
        if (t >= FL) return 1'b1;
        slot = t / BIT_CYC;
        if (slot == 0) return 1'b0;
        if (slot <= int'(DBIT)) return d[slot-1];
        if (PAR == 1 && slot == int'(DBIT) + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [7:0] d, input logic [7:0] exp_byte, input logic exp_par,
                             input bit scramble, input bit poke, input bit early,
                             input int exp_gap, input string tag);
        int wave_err, busy_err, done_err, done_seen, first_bad, e0, tend, slot;
        logic [7:0] dec;
        logic dec_start, dec_par, dec_stop;
        dec = '0; dec_start = 1'bx; dec_par = 1'bx; dec_stop = 1'bx;
        bus.tx_start = 1'b1;
        bus.tx_bus   = d;
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        e0 = cyc;
        if (exp_gap > 0) check({tag, " accept_gap"}, 32'(e0 - last_e0), 32'(exp_gap));
        last_e0 = e0;
        wave_err = 0; busy_err = 0; done_err = 0; done_seen = 0; first_bad = -1;
        tend = early ? FL : FL + 1;
        for (int t = 0; t <= tend; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            if (tx_line !== model_tx(d, t)) begin
                wave_err++;
                if (first_bad < 0) first_bad = t;
            end
            if (bus.tx_busy !== (t < FL)) busy_err++;
            if (bus.tx_done_tick !== (t == FL)) done_err++;
            if (bus.tx_done_tick === 1'b1) done_seen++;
            if (t < FL && (t % BIT_CYC) == BIT_CYC / 2) begin
                slot = t / BIT_CYC;
                if (slot == 0) dec_start = tx_line;
                else if (slot <= int'(DBIT)) dec[slot-1] = tx_line;
                else if (PAR == 1 && slot == int'(DBIT) + 1) dec_par = tx_line;
                else dec_stop = tx_line;
            end
            if (scramble) bus.tx_bus = 8'($urandom);
            if (poke && t == 100) begin
                bus.tx_start = 1'b1;
                bus.tx_bus   = 8'hA5;
            end else if (poke && t == 101) begin
                bus.tx_start = 1'b0;
            end
        end
        check({tag, " tx_wave_errs"}, 32'(wave_err), 32'd0);
        if (wave_err != 0) $display("  first bad tx cycle %0d of frame %s", first_bad, tag);
        check({tag, " busy_errs"}, 32'(busy_err), 32'd0);
        check({tag, " done_errs"}, 32'(done_err), 32'd0);
        check({tag, " done_count"}, 32'(done_seen), 32'd1);
        check({tag, " start_bit"}, 32'(dec_start), 32'd0);
        check({tag, " decoded"}, 32'(dec), 32'(exp_byte));
        check({tag, " stop_bit"}, 32'(dec_stop), 32'd1);
`ifdef UART_TX_PARITY_EN
        check({tag, " parity"}, 32'(dec_par), 32'(exp_par));
`endif
    endtask

    typedef struct {
        logic [7:0] data;
        bit         scramble;
        bit         poke;
        bit         early;
        logic [7:0] exp_byte;
        logic       exp_par;
    } vec_t;

    initial begin
        vec_t tbl[9];
        int   exp_gap;
        bit   prev_early;
        int   prev_idle;
        int   d0;

        tbl[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0};
        tbl[1] = '{8'h72, 1'b0, 1'b0, 1'b0, 8'h72, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};
        tbl[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
        tbl[5] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0};
        tbl[6] = '{8'h07, 1'b0, 1'b0, 1'b0, 8'h07, 1'b1};
        tbl[7] = '{8'h03, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0};
        tbl[8] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};

        rst_n        = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_bus   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 32'(tx_line), 32'd1);
        check("reset busy", 32'(bus.tx_busy), 32'd0);
        check("reset done", 32'(bus.tx_done_tick), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle tx", 32'(tx_line), 32'd1);

        // Consecutive rows are back-to-back: start raised in the cycle after done, or in the done cycle.
        for (int i = 0; i < 9; i++) begin
            exp_gap = (i == 0) ? 0 : (tbl[i-1].early ? FL + 1 : FL + 2);
            run_frame(tbl[i].data, tbl[i].exp_byte, tbl[i].exp_par, tbl[i].scramble,
                      tbl[i].poke, tbl[i].early, exp_gap, $sformatf("tbl%0d", i));
        end

        prev_early = 1'b0;
        prev_idle  = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            bit scr, erl;
            int idle;
            d    = 8'($urandom);
            scr  = 1'($urandom_range(0, 1));
            erl  = (i < 15) && ($urandom_range(0, 3) == 0);
            idle = erl ? 0 : int'($urandom_range(0, 3));
            exp_gap = prev_early ? FL + 1 : FL + 2 + prev_idle;
            run_frame(d, d, ^d, scr, 1'b0, erl, exp_gap, $sformatf("rnd%0d", i));
            repeat (idle) begin @(posedge clk); #1; end
            prev_early = erl;
            prev_idle  = idle;
        end

        // Reset during data bit 3 abandons the frame with no done pulse.
        bus.tx_start = 1'b1;
        bus.tx_bus   = 8'h5A;
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        check("rst_mid busy_before", 32'(bus.tx_busy), 32'd1);
        repeat (4 * BIT_CYC + 20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid tx", 32'(tx_line), 32'd1);
        check("rst_mid busy", 32'(bus.tx_busy), 32'd0);
        check("rst_mid done", 32'(bus.tx_done_tick), 32'd0);
        d0 = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (FL + 50) @(posedge clk);
        #1;
        check("rst_mid no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid idle_tx", 32'(tx_line), 32'd1);
        check("rst_mid idle_busy", 32'(bus.tx_busy), 32'd0);
        run_frame(8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
